clk_divider_bank: RTL and testbench

Parametrised bank of NCH independent clock dividers/tick generators, all driven from the single system clock. Each channel generates either a square-wave divided clock or a one-cycle tick strobe, with its own runtime divisor. Divisor and mode changes are shadowed and take effect only at a period boundary. A global sync input phase-aligns all running channels. It feeds game-speed timing, display refresh strobes and scan clocks.

---
 rtl/clk_divider_bank_if.sv | 17 +
 rtl/clk_divider_bank.sv | 136 +++++++++++++
 tb/tb_clk_divider_bank.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/clk_divider_bank_if.sv
// Control/status bundle for clk_divider_bank: per-channel enable, mode, divisor,
// the shared sync strobe and the registered channel outputs.
interface clk_divider_bank_if #(
  parameter int NCH   = 4,
  parameter int WIDTH = 27
);
  logic [NCH-1:0]       en;
  logic [NCH-1:0]       mode;
  logic [NCH*WIDTH-1:0] div;
  logic                 sync;
  logic [NCH-1:0]       y;
  logic [NCH-1:0]       tick;
  logic [NCH-1:0]       running;

  modport master (output en, mode, div, sync, input  y, tick, running);
  modport slave  (input  en, mode, div, sync, output y, tick, running);
endinterface

// File: rtl/clk_divider_bank.sv
// Bank of NCH independent divided-clock / tick generators with shadowed divisor
// and mode (reloaded only at wrap, sync or start) and a shared phase-align sync.
module clk_divider_ch #(
  parameter int WIDTH = 27
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             i_en,
  input  logic             i_mode,
  input  logic [WIDTH-1:0] i_div,
  input  logic             i_sync,
  output logic             o_y,
  output logic             o_tick,
  output logic             o_running
);
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_p_act;
  logic             r_mode_act;
  logic             r_y;
  logic             r_tick;
  logic             w_wrap;
  logic             w_half;
  logic             w_mode_chg;

  // With P_act=0 both compares hit every cycle, so y toggles once per edge.
  assign w_wrap     = (r_count == r_p_act);
  assign w_half     = (r_count == (r_p_act >> 1));
  assign w_mode_chg = (i_mode != r_mode_act);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (i_en)  w_state_nxt = ST_RUN;
      ST_RUN:  if (!i_en) w_state_nxt = ST_IDLE;
      default:            w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    o_running = (r_state == ST_RUN);
    o_y       = r_y;
    o_tick    = r_tick;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_count    <= '0;
      r_p_act    <= '0;
      r_mode_act <= 1'b0;
      r_y        <= 1'b0;
      r_tick     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_count <= '0;
          r_y     <= 1'b0;
          r_tick  <= 1'b0;
          if (i_en) begin
            r_p_act    <= i_div;
            r_mode_act <= i_mode;
          end
        end
        default: begin
          if (!i_en || i_sync) begin
            r_count <= '0;
            r_y     <= 1'b0;
            r_tick  <= 1'b0;
            if (i_en) begin
              r_p_act    <= i_div;
              r_mode_act <= i_mode;
            end
          end else if (w_wrap) begin
            r_count    <= '0;
            r_p_act    <= i_div;
            r_mode_act <= i_mode;
            // A mode switch restarts both outputs low on the wrap edge.
            if (w_mode_chg) begin
              r_y    <= 1'b0;
              r_tick <= 1'b0;
            end else if (!r_mode_act) begin
              r_y    <= ~r_y;
              r_tick <= 1'b0;
            end else begin
              r_y    <= 1'b0;
              r_tick <= 1'b1;
            end
          end else begin
            r_count <= r_count + 1'b1;
            r_tick  <= 1'b0;
            if (!r_mode_act) r_y <= r_y ^ w_half;
            else             r_y <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule

module clk_divider_bank #(
  parameter int NCH   = 4,
  parameter int WIDTH = 27
) (
  input  logic               clk,
  input  logic               clr,
  clk_divider_bank_if.slave  bus
);
  logic [NCH-1:0] w_y;
  logic [NCH-1:0] w_tick;
  logic [NCH-1:0] w_running;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    clk_divider_ch #(.WIDTH(WIDTH)) u_ch (
      .clk       (clk),
      .clr       (clr),
      .i_en      (bus.en[gi]),
      .i_mode    (bus.mode[gi]),
      .i_div     (bus.div[gi*WIDTH +: WIDTH]),
      .i_sync    (bus.sync),
      .o_y       (w_y[gi]),
      .o_tick    (w_tick[gi]),
      .o_running (w_running[gi])
    );
  end

  assign bus.y       = w_y;
  assign bus.tick    = w_tick;
  assign bus.running = w_running;
endmodule

// File: tb/tb_clk_divider_bank.sv
// Self-checking bench for clk_divider_bank: vector table on channel 0, directed
// reset/shadow/sync sequences, then randomized traffic against a period model.
module tb_clk_divider_bank;
  localparam int NCH   = 4;
  localparam int WIDTH = 27;

  logic clk = 1'b0;
  logic clr = 1'b1;
  int   tests = 0;
  int   fails = 0;

  clk_divider_bank_if #(.NCH(NCH), .WIDTH(WIDTH)) bus ();
  clk_divider_bank #(.NCH(NCH), .WIDTH(WIDTH)) dut (.clk(clk), .clr(clr), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    bit en; bit mode; bit sync; int div;
    bit ey; bit et; bit er;
  } vec_t;
  vec_t tbl[$];

  // Reference state: count position, active period/mode, and whether the last
  // edge was a wrap that stayed in tick mode (the only time tick reads 1).
  bit m_run[NCH];
  int m_c[NCH];
  int m_p[NCH];
  bit m_md[NCH];
  bit m_tf[NCH];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_ch(input int ch, input bit e, input bit m, input int d);
    bus.en[ch]                = e;
    bus.mode[ch]              = m;
    bus.div[ch*WIDTH +: WIDTH] = WIDTH'(d);
  endtask

  task automatic all_idle();
    bus.en = '0; bus.mode = '0; bus.div = '0; bus.sync = 1'b0;
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < NCH; ch++) begin
      m_run[ch] = 0; m_c[ch] = 0; m_p[ch] = 0; m_md[ch] = 0; m_tf[ch] = 0;
    end
  endtask

  task automatic model_step();
    for (int ch = 0; ch < NCH; ch++) begin
      bit e; bit m; int d;
      e = bus.en[ch]; m = bus.mode[ch]; d = int'(bus.div[ch*WIDTH +: WIDTH]);
      if (!m_run[ch]) begin
        if (e) begin m_run[ch] = 1; m_c[ch] = 0; m_p[ch] = d; m_md[ch] = m; m_tf[ch] = 0; end
      end else if (!e) begin
        m_run[ch] = 0; m_c[ch] = 0; m_tf[ch] = 0;
      end else if (bus.sync) begin
        m_c[ch] = 0; m_p[ch] = d; m_md[ch] = m; m_tf[ch] = 0;
      end else if (m_c[ch] == m_p[ch]) begin
        m_tf[ch] = m_md[ch] && m; m_c[ch] = 0; m_p[ch] = d; m_md[ch] = m;
      end else begin
        m_c[ch]++; m_tf[ch] = 0;
      end
    end
  endtask

  initial begin
    logic [NCH-1:0] ey, et, er;
    int rise[$];
    int fall[$];
    bit prev;
    bit seen;

    all_idle();
    #1;
    chk("reset_y", bus.y, 0);
    chk("reset_tick", bus.tick, 0);
    chk("reset_running", bus.running, 0);
    @(negedge clk);
    clr = 1'b0;

    // ---- channel 0 vector table ----
    tbl.push_back('{1,0,0,4, 0,0,1});
    tbl.push_back('{1,1,0,1, 0,0,1});
    tbl.push_back('{1,1,0,1, 0,0,1});
    tbl.push_back('{1,1,0,1, 1,0,1});
    tbl.push_back('{1,1,0,1, 1,0,1});
    tbl.push_back('{1,1,0,1, 0,0,1});
    tbl.push_back('{1,1,0,1, 0,0,1});
    tbl.push_back('{1,1,0,1, 0,1,1});
    tbl.push_back('{1,1,0,1, 0,0,1});
    tbl.push_back('{1,1,1,2, 0,0,1});
    tbl.push_back('{1,1,0,2, 0,0,1});
    tbl.push_back('{1,1,0,2, 0,0,1});
    tbl.push_back('{1,1,0,2, 0,1,1});
    tbl.push_back('{0,1,0,2, 0,0,0});
    tbl.push_back('{0,0,0,0, 0,0,0});
    tbl.push_back('{1,0,0,0, 0,0,1});
    tbl.push_back('{1,0,0,0, 1,0,1});
    tbl.push_back('{1,0,0,0, 0,0,1});
    tbl.push_back('{1,0,0,0, 1,0,1});
    tbl.push_back('{0,0,1,0, 0,0,0});
    tbl.push_back('{1,1,0,0, 0,0,1});
    tbl.push_back('{1,1,0,0, 0,1,1});
    tbl.push_back('{1,1,0,0, 0,1,1});
    tbl.push_back('{0,1,0,0, 0,0,0});
    foreach (tbl[i]) begin
      set_ch(0, tbl[i].en, tbl[i].mode, tbl[i].div);
      bus.sync = tbl[i].sync;
      @(negedge clk);
      chk($sformatf("tbl%0d_y", i), bus.y, {{(NCH-1){1'b0}}, tbl[i].ey});
      chk($sformatf("tbl%0d_tick", i), bus.tick, {{(NCH-1){1'b0}}, tbl[i].et});
      chk($sformatf("tbl%0d_run", i), bus.running, {{(NCH-1){1'b0}}, tbl[i].er});
    end
    all_idle();

    // ---- asynchronous reset while y is high ----
    set_ch(0, 1, 0, 9);
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (bus.y[0]) seen = 1;
    end
    chk("rst_wait_y_high", 32'(seen), 1);
    clr = 1'b1;
    #1;
    chk("rst_async_y", bus.y, 0);
    chk("rst_async_tick", bus.tick, 0);
    chk("rst_async_running", bus.running, 0);
    all_idle();
    @(negedge clk);
    clr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_idle_outputs", {bus.y, bus.tick, bus.running}, 0);
    end

    // ---- shadowed divisor: 9 -> 3 at count 2 ----
    set_ch(0, 1, 0, 9);
    prev = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.y[0] && !prev) rise.push_back(c);
      if (!bus.y[0] && prev) fall.push_back(c);
      prev = bus.y[0];
      if (c == 2) set_ch(0, 1, 0, 3);
    end
    chk("shadow_rise_cnt", 32'(rise.size() >= 2), 1);
    chk("shadow_fall_cnt", 32'(fall.size() >= 3), 1);
    if (rise.size() >= 2 && fall.size() >= 3) begin
      chk("shadow_rise0", rise[0], 5);
      chk("shadow_fall0", fall[0], 10);
      chk("shadow_rise1", rise[1], 12);
      chk("shadow_fall1", fall[1], 14);
      chk("shadow_fall2", fall[2], 18);
    end
    all_idle();
    @(negedge clk);

    // ---- sync aligns ch0 and ch2, idle ch3 unaffected ----
    set_ch(0, 1, 0, 7);
    repeat (3) @(negedge clk);
    set_ch(2, 1, 0, 7);
    repeat (5) @(negedge clk);
    bus.sync = 1'b1;
    @(negedge clk);
    bus.sync = 1'b0;
    for (int k = 0; k < 20; k++) begin
      chk($sformatf("sync_y0_k%0d", k), 32'(bus.y[0]), 32'((k % 8) > 3));
      chk($sformatf("sync_y2_k%0d", k), 32'(bus.y[2]), 32'((k % 8) > 3));
      chk("sync_ch3_idle", {bus.y[3], bus.tick[3], bus.running[3]}, 0);
      @(negedge clk);
    end

    // ---- randomized traffic against the reference model ----
    clr = 1'b1;
    all_idle();
    model_reset();
    @(negedge clk);
    clr = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        er[ch] = m_run[ch];
        ey[ch] = m_run[ch] && !m_md[ch] && (m_c[ch] > m_p[ch] / 2);
        et[ch] = m_run[ch] && m_md[ch] && m_tf[ch];
      end
      chk($sformatf("rand%0d_y", cyc), bus.y, ey);
      chk($sformatf("rand%0d_tick", cyc), bus.tick, et);
      chk($sformatf("rand%0d_run", cyc), bus.running, er);
      bus.sync = ($urandom_range(0, 39) == 0);
      for (int ch = 0; ch < NCH; ch++) begin
        if ($urandom_range(0, 29) == 0) bus.en[ch] = ~bus.en[ch];
        if ($urandom_range(0, 7) == 0)
          set_ch(ch, bus.en[ch], 1'($urandom_range(0, 1)), int'($urandom_range(1, 10)));
      end
      model_step();
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
